shift_unit_seq: RTL and testbench



---
 rtl/shift_unit_seq.sv | 140 ++++++++++++++
 tb/tb_shift_unit_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/shift_unit_seq.sv
// Iterative shift/rotate unit: one bit position per clock, start/busy/done handshake.
// cout holds the last bit shifted or rotated out; f holds the result until the next start.
module shift_unit_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [AMT_W-1:0] amount,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic [1:0] ModeLogical  = 2'b00;
    localparam logic [1:0] ModeArith    = 2'b01;
    localparam logic [1:0] ModeRotate   = 2'b10;
    localparam logic [1:0] ModeRotCarry = 2'b11;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic               cout_q, cout_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [1:0]         mode_q, mode_d;

    logic               accept;
    logic [WIDTH-1:0]   step_f;
    logic               step_cout;
    logic               fill;

    assign accept = (state_q == StIdle) && start;

    // One-bit step on the latched operation; fill is the bit entering the vacated end.
    always_comb begin
        fill      = 1'b0;
        step_f    = f_q;
        step_cout = cout_q;
        if (!dir_q) begin
            unique case (mode_q)
                ModeLogical:  fill = 1'b0;
                ModeArith:    fill = f_q[WIDTH-1];
                ModeRotate:   fill = f_q[0];
                ModeRotCarry: fill = cout_q;
                default:      fill = 1'b0;
            endcase
            step_f    = {fill, f_q[WIDTH-1:1]};
            step_cout = f_q[0];
        end else begin
            unique case (mode_q)
                ModeLogical:  fill = 1'b0;
                ModeArith:    fill = 1'b0;
                ModeRotate:   fill = f_q[WIDTH-1];
                ModeRotCarry: fill = cout_q;
                default:      fill = 1'b0;
            endcase
            step_f    = {f_q[WIDTH-2:0], fill};
            step_cout = f_q[WIDTH-1];
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            f_q     <= '0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= ModeLogical;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (amount == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                if (cnt_q == AMT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: load on accepted start, step while shifting, hold otherwise.
    always_comb begin
        f_d    = f_q;
        cout_d = cout_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        if (accept) begin
            f_d    = x;
            cout_d = cin;
            cnt_d  = amount;
            dir_d  = dir;
            mode_d = mode;
        end else if (state_q == StShift) begin
            f_d    = step_f;
            cout_d = step_cout;
            cnt_d  = cnt_q - AMT_W'(1);
        end
    end

    // Outputs.
    always_comb begin
        busy = (state_q == StShift);
        done = (state_q == StDone);
        f    = f_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq at WIDTH=8 with hand-computed results.
module tb_shift_unit_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] x;
    logic [3:0] amount;
    logic       dir;
    logic [1:0] mode;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] f;
    logic       cout;

    int checks = 0;
    int errors = 0;

    shift_unit_seq #(
        .WIDTH(8),
        .AMT_W(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .amount(amount),
        .dir   (dir),
        .mode  (mode),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .f     (f),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start one operation, watch handshake timing, then check result and pulse width.
    task automatic run_op(input string tag, input logic [7:0] xi, input logic [3:0] amt,
                          input logic di, input logic [1:0] mo, input logic ci,
                          input logic [7:0] ef, input logic ec, input bit poke);
        int busy_cycles = 0;
        int done_at     = -1;
        int overlap     = 0;
        @(negedge clk);
        start  = 1'b1;
        x      = xi;
        amount = amt;
        dir    = di;
        mode   = mo;
        cin    = ci;
        @(posedge clk);
        #1;
        start  = 1'b0;
        x      = ~xi;
        amount = 4'd0;
        dir    = ~di;
        mode   = ~mo;
        cin    = ~ci;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(negedge clk);
            if (busy && done) overlap = 1;
            if (busy) busy_cycles++;
            if (done) done_at = c;
            start = (poke && busy_cycles == 1) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check($sformatf("%s_done_cycle", tag), 32'(done_at), 32'(amt) + 32'd1);
        check($sformatf("%s_busy_cycles", tag), 32'(busy_cycles), 32'(amt));
        check($sformatf("%s_busy_done_overlap", tag), 32'(overlap), 32'd0);
        check($sformatf("%s_f", tag), 32'(f), 32'(ef));
        check($sformatf("%s_cout", tag), 32'(cout), 32'(ec));
        @(negedge clk);
        check($sformatf("%s_done_one_cycle", tag), 32'(done), 32'd0);
        check($sformatf("%s_idle_after", tag), 32'(busy), 32'd0);
        check($sformatf("%s_f_hold", tag), 32'(f), 32'(ef));
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        x      = 8'h5A;
        amount = 4'd3;
        dir    = 1'b0;
        mode   = 2'b00;
        cin    = 1'b1;

        #12;
        check("reset_f", 32'(f), 32'h00);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // x, amount, dir, mode, cin, expected f, expected cout, poke start while busy
        run_op("lsr1",      8'hFD, 4'd1,  1'b0, 2'b00, 1'b0, 8'h7E, 1'b1, 1'b0);
        run_op("asr3",      8'h8E, 4'd3,  1'b0, 2'b01, 1'b0, 8'hF1, 1'b1, 1'b1);
        run_op("rol4",      8'hCD, 4'd4,  1'b1, 2'b10, 1'b0, 8'hDC, 1'b0, 1'b0);
        run_op("rcr1",      8'h8F, 4'd1,  1'b0, 2'b11, 1'b0, 8'h47, 1'b1, 1'b0);
        run_op("rcr9",      8'hCD, 4'd9,  1'b0, 2'b11, 1'b0, 8'hCD, 1'b0, 1'b0);
        run_op("amt0",      8'hA5, 4'd0,  1'b0, 2'b10, 1'b1, 8'hA5, 1'b1, 1'b0);
        run_op("lsr12",     8'hFF, 4'd12, 1'b0, 2'b00, 1'b1, 8'h00, 1'b0, 1'b0);
        run_op("asr10",     8'h80, 4'd10, 1'b0, 2'b01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("ror11",     8'h96, 4'd11, 1'b0, 2'b10, 1'b0, 8'hD2, 1'b1, 1'b0);
        run_op("rcl1",      8'h01, 4'd1,  1'b1, 2'b11, 1'b1, 8'h03, 1'b0, 1'b0);

        // Reset asserted mid-operation after the second step.
        @(negedge clk);
        start  = 1'b1;
        x      = 8'hFF;
        amount = 4'd5;
        dir    = 1'b1;
        mode   = 2'b00;
        cin    = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_f_after_2", 32'(f), 32'hFC);
        check("mid_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_f", 32'(f), 32'h00);
        check("rst_mid_cout", 32'(cout), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_state", 32'(dut.state_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        run_op("rerun_lsl8", 8'hFF, 4'd8, 1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
